// File: rtl/exc_sequencer.sv
// exc_sequencer: multi-cycle exception / interrupt sequencer for the pipelined MIPS core.
//
// Arbitrates M-stage synchronous exceptions, masked interrupts and eret, and owns
// EXL, EPC, BD and the Cause fields. An accepted exception or interrupt goes through
// flush -> drain (waits for the MD unit) -> redirect. An accepted eret goes through
// one redirect cycle back to EPC.
//
// Build option: EXC_IRQ_LATCH_EN
//   undefined : cause_ip is a registered copy of irq (level mode).
//   defined   : a rising edge on irq[i] sets a sticky pending bit, and cause_ip shows the
//               pending bits. Unmasked pending bits clear when an interrupt is accepted.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   m_valid, m_exc,      M-stage instruction: valid, exception code (0 = none),
//   m_pc, m_bd, m_eret   PC, branch-delay-slot flag, eret flag
//   irq                  interrupt request lines
//   status_ie, status_im global interrupt enable, interrupt mask
//   md_busy              multiply/divide unit mid-operation
//   have2handle          exception/interrupt accepted this cycle (combinational)
//   flush                per-stage pipeline register reset (bit 0 = D ... MSB = M)
//   redirect, redirect_pc one-cycle PC load strobe and its target
//   epc, cause_exc, cause_ip, cause_bd, exl   architectural exception state
//   busy                 sequencer is not idle
//
// state    | meaning
// S_IDLE   | sampling the M stage for exceptions, interrupts and eret
// S_DRAIN  | full flush, waiting for md_busy to fall
// S_REDIR  | full flush, redirect to HANDLER_ADDR for one cycle
// S_ERET   | flush below M, redirect to EPC for one cycle, clear EXL

module exc_sequencer #(
  parameter int N_IRQ   = 6,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 5,
  parameter int N_STAGE = 4,
  parameter logic [PC_W-1:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_valid,
  input  logic [EXC_W-1:0]   m_exc,
  input  logic [PC_W-1:0]    m_pc,
  input  logic               m_bd,
  input  logic               m_eret,
  input  logic [N_IRQ-1:0]   irq,
  input  logic               status_ie,
  input  logic [N_IRQ-1:0]   status_im,
  input  logic               md_busy,
  output logic               have2handle,
  output logic [N_STAGE-1:0] flush,
  output logic               redirect,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    epc,
  output logic [EXC_W-1:0]   cause_exc,
  output logic [N_IRQ-1:0]   cause_ip,
  output logic               cause_bd,
  output logic               exl,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REDIR, S_ERET} state_t;

  localparam logic [N_STAGE-1:0] FLUSH_ALL  = '1;
  // Every stage except M: lets the eret itself commit.
  localparam logic [N_STAGE-1:0] FLUSH_NO_M = {1'b0, {(N_STAGE-1){1'b1}}};

  state_t             r_state, w_next;
  logic [PC_W-1:0]    r_epc;
  logic [EXC_W-1:0]   r_cause_exc;
  logic [N_IRQ-1:0]   r_cause_ip;
  logic               r_cause_bd;
  logic               r_exl;

  logic               w_sync_exc;
  logic               w_irq_take;
  logic               w_accept;
  logic               w_accept_irq;
  logic [N_STAGE-1:0] w_flush;
  logic               w_redirect;
  logic [PC_W-1:0]    w_redirect_pc;

  assign w_sync_exc = (m_exc != '0);
  assign w_irq_take = status_ie & ~r_exl & (|(r_cause_ip & status_im));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_accept_irq  = 1'b0;
    w_flush       = '0;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    case (r_state)
      S_IDLE: begin
        if (m_valid) begin
          if (w_sync_exc || w_irq_take) begin
            w_accept     = 1'b1;
            w_accept_irq = ~w_sync_exc;
            w_flush      = FLUSH_ALL;
            w_next       = S_DRAIN;
          end else if (m_eret) begin
            w_flush = FLUSH_NO_M;
            w_next  = S_ERET;
          end
        end
      end
      S_DRAIN: begin
        w_flush = FLUSH_ALL;
        if (!md_busy) w_next = S_REDIR;
      end
      S_REDIR: begin
        w_flush       = FLUSH_ALL;
        w_redirect    = 1'b1;
        w_redirect_pc = HANDLER_ADDR;
        w_next        = S_IDLE;
      end
      S_ERET: begin
        w_flush       = FLUSH_NO_M;
        w_redirect    = 1'b1;
        w_redirect_pc = r_epc;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc       <= '0;
      r_cause_exc <= '0;
      r_cause_bd  <= 1'b0;
      r_exl       <= 1'b0;
    end else if (w_accept) begin
      r_cause_exc <= w_accept_irq ? '0 : m_exc;
      r_exl       <= 1'b1;
      // A nested exception keeps the EPC/BD of the outer one.
      if (!r_exl) begin
        r_epc      <= m_bd ? (m_pc - PC_W'(4)) : m_pc;
        r_cause_bd <= m_bd;
      end
    end else if (r_state == S_ERET) begin
      r_exl <= 1'b0;
    end
  end

`ifdef EXC_IRQ_LATCH_EN
  logic [N_IRQ-1:0] r_irq_prev;
  logic [N_IRQ-1:0] w_irq_rise;
  logic [N_IRQ-1:0] w_ip_clr;

  assign w_irq_rise = irq & ~r_irq_prev;
  assign w_ip_clr   = w_accept_irq ? (r_cause_ip & status_im) : '0;

  // A rise in the same cycle as the clear re-sets the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_prev <= '0;
      r_cause_ip <= '0;
    end else begin
      r_irq_prev <= irq;
      r_cause_ip <= (r_cause_ip & ~w_ip_clr) | w_irq_rise;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cause_ip <= '0;
    else        r_cause_ip <= irq;
  end
`endif

  // Gating with rst_n makes the combinational outputs drop as soon as reset asserts.
  assign have2handle = w_accept & rst_n;
  assign flush       = rst_n ? w_flush : '0;
  assign redirect    = w_redirect & rst_n;
  assign redirect_pc = rst_n ? w_redirect_pc : '0;
  assign epc         = r_epc;
  assign cause_exc   = r_cause_exc;
  assign cause_ip    = r_cause_ip;
  assign cause_bd    = r_cause_bd;
  assign exl         = r_exl;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_exc_sequencer.sv
module tb_exc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        m_valid;
  logic [4:0]  m_exc;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_eret;
  logic [5:0]  irq;
  logic        status_ie;
  logic [5:0]  status_im;
  logic        md_busy;
  logic        have2handle;
  logic [3:0]  flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [4:0]  cause_exc;
  logic [5:0]  cause_ip;
  logic        cause_bd;
  logic        exl;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  exc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_exc(m_exc), .m_pc(m_pc), .m_bd(m_bd), .m_eret(m_eret),
    .irq(irq), .status_ie(status_ie), .status_im(status_im), .md_busy(md_busy),
    .have2handle(have2handle), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .epc(epc), .cause_exc(cause_exc),
    .cause_ip(cause_ip), .cause_bd(cause_bd), .exl(exl), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_m();
    m_valid = 1'b0; m_exc = '0; m_pc = '0; m_bd = 1'b0; m_eret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr_m(); irq = '0; status_ie = 1'b0; status_im = '0; md_busy = 1'b0;
    // Combinational outputs stay low in reset even with an exception presented.
    m_valid = 1'b1; m_exc = 5'd4;
    tick(); tick();
    chk("rst_h2h", have2handle, 0);
    chk("rst_flush", flush, 0);
    chk("rst_epc", epc, 0);
    chk("rst_exl", exl, 0);
    chk("rst_busy", busy, 0);
    clr_m();
    rst_n = 1'b1;
    tick();

    // Exception, no MD activity
    m_valid = 1'b1; m_exc = 5'd4; m_pc = 32'h3010;
    #1;
    chk("exc_h2h", have2handle, 1);
    chk("exc_flush", flush, 4'b1111);
    chk("exc_redir0", redirect, 0);
    tick();
    chk("drain_h2h", have2handle, 0);
    chk("drain_busy", busy, 1);
    chk("drain_flush", flush, 4'b1111);
    chk("drain_redir", redirect, 0);
    chk("exc_epc", epc, 32'h3010);
    chk("exc_cause", cause_exc, 4);
    chk("exc_exl", exl, 1);
    chk("exc_bd", cause_bd, 0);
    clr_m();
    tick();
    chk("redir", redirect, 1);
    chk("redir_pc", redirect_pc, 32'h4180);
    chk("redir_flush", flush, 4'b1111);
    tick();
    chk("idle_redir", redirect, 0);
    chk("idle_busy", busy, 0);

    // Eret back to EPC
    m_valid = 1'b1; m_eret = 1'b1;
    #1;
    chk("eret_flush", flush, 4'b0111);
    chk("eret_h2h", have2handle, 0);
    tick();
    clr_m();
    chk("eret_redir", redirect, 1);
    chk("eret_pc", redirect_pc, 32'h3010);
    chk("eret_flush2", flush, 4'b0111);
    chk("eret_exl_hold", exl, 1);
    tick();
    chk("eret_exl0", exl, 0);
    chk("eret_redir0", redirect, 0);

    // Branch-delay exception
    m_valid = 1'b1; m_exc = 5'd12; m_pc = 32'h3004; m_bd = 1'b1;
    #1;
    chk("bd_h2h", have2handle, 1);
    tick();
    clr_m();
    chk("bd_epc", epc, 32'h3000);
    chk("bd_flag", cause_bd, 1);
    chk("bd_cause", cause_exc, 12);
    tick(); tick();
    chk("bd_idle", busy, 0);

    // exl=1 blocks the interrupt; nested sync exception keeps EPC/BD
    irq = 6'b000100; status_im = 6'b000100; status_ie = 1'b1;
    tick();
    m_valid = 1'b1;
    #1;
    chk("exl_gate", have2handle, 0);
    m_exc = 5'd10; m_pc = 32'h3020;
    #1;
    chk("nest_h2h", have2handle, 1);
    tick();
    clr_m();
    chk("nest_epc", epc, 32'h3000);
    chk("nest_cause", cause_exc, 10);
    chk("nest_bd", cause_bd, 1);
    tick(); tick();
    m_valid = 1'b1; m_eret = 1'b1;
    tick();
    clr_m();
    chk("eret2_pc", redirect_pc, 32'h3000);
    tick();
    chk("eret2_exl", exl, 0);

    // No real instruction -> no accept; masked line -> no accept
    #1;
    chk("nvalid_h2h", have2handle, 0);
    chk("ip_view", cause_ip, 6'b000100);
    status_im = '0;
    m_valid = 1'b1;
    #1;
    chk("mask_h2h", have2handle, 0);

    // Interrupt waits for MD
    status_im = 6'b000100; m_pc = 32'h3040; md_busy = 1'b1;
    #1;
    chk("int_h2h", have2handle, 1);
    chk("int_flush", flush, 4'b1111);
    tick();
    clr_m();
    chk("int_cause", cause_exc, 0);
    chk("int_epc", epc, 32'h3040);
    chk("int_exl", exl, 1);
    for (int i = 0; i < 3; i++) begin
      chk("md_busy_st", busy, 1);
      chk("md_flush", flush, 4'b1111);
      chk("md_redir", redirect, 0);
      if (i < 2) tick();
    end
    md_busy = 1'b0;
    tick();
    chk("md_redir1", redirect, 1);
    chk("md_redir_pc", redirect_pc, 32'h4180);
    tick();
    m_valid = 1'b1;
    #1;
    chk("int_exl_gate", have2handle, 0);
    clr_m();

    // Reset mid-DRAIN
    m_valid = 1'b1; m_exc = 5'd4; m_pc = 32'h3050; md_busy = 1'b1;
    tick();
    clr_m();
    chk("rd_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rd_busy0", busy, 0);
    chk("rd_flush0", flush, 0);
    chk("rd_redir0", redirect, 0);
    chk("rd_exl0", exl, 0);
    chk("rd_epc0", epc, 0);
    chk("rd_ip0", cause_ip, 0);
    md_busy = 1'b0; irq = '0; status_im = '0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef EXC_IRQ_LATCH_EN
    // One-cycle pulse on a masked line stays pending until unmasked and accepted.
    irq = 6'b000001;
    tick();
    irq = '0;
    tick(); tick();
    chk("lat_hold", cause_ip, 6'b000001);
    m_valid = 1'b1;
    #1;
    chk("lat_mask", have2handle, 0);
    status_im = 6'b000001;
    #1;
    chk("lat_h2h", have2handle, 1);
    tick();
    clr_m();
    chk("lat_clr", cause_ip, 0);
    tick(); tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
